// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus transaction path.
// Holds the sequencer state encoding, the default phase timing (tied to the
// bus signal generator's cycle length) and the read/write direction codes.
package rtc_pkg;

  // Cycle length of the signals_rtc generator; a bus phase must match it.
  localparam int RTC_CYCLE_LEN    = 32;
  localparam int PHASE_CYCLES_DEF = RTC_CYCLE_LEN;
  localparam int GAP_CYCLES_DEF   = 2;

  // Direction codes captured with a request.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Sequencer state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/rtc_transaction_ctrl_phase_timer.sv
// rtc_phase_timer: per-state phase timer.
// The count is cleared by load and advances once per cycle; it stops
// (no wrap) once the programmed length has elapsed.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   load        clear the count (asserted on every state entry)
//   len         number of cycles the current state lasts (>= 1)
//   expired     high in the last cycle of the programmed length
module rtc_phase_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] len,
  output logic             expired
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   elapsed;

  // Cycles spent in the state including the current one; one bit wider so
  // a saturated count cannot overflow the comparison.
  assign elapsed = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign expired = (elapsed >= {1'b0, len});

  // Elapsed-cycle counter: clear on load, hold once the length is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (load) begin
      count <= {WIDTH{1'b0}};
    end else if (!expired) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rtc_transaction_ctrl.sv
// rtc_transaction_ctrl: turns one read/write request into the two-phase
// multiplexed RTC bus sequence (address phase, gap, data phase, finish) that
// drives the signals_rtc generator, and captures read data on its latch strobe.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, rw, addr,      request strobe (accepted in IDLE only) with its
//   wdata                 direction, register address and write byte
//   busy, done            transaction in progress / one-cycle completion pulse
//   rdata                 last read byte, held until the next read completes
//   en_signals, read,     generator enable, direction and address/data select
//   dato
//   bus_out               byte presented on the AD bus
//   bus_in, ll            sampled AD bus value and generator latch strobe
module rtc_transaction_ctrl
  import rtc_pkg::*;
#(
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       en_signals,
  output logic       read,
  output logic       dato,
  output logic [7:0] bus_out,
  input  logic [7:0] bus_in,
  input  logic       ll
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic          load;
  logic          expired;
  logic [CW-1:0] len;
  logic          accept;
  logic          rw_q;
  logic          rw_n;
  logic [7:0]    addr_q;
  logic [7:0]    addr_n;
  logic [7:0]    wdata_q;
  logic [7:0]    wdata_n;
  logic [7:0]    rdata_shadow;
  logic [7:0]    bus_next;

  assign accept = (state == ST_IDLE) && start;

  rtc_phase_timer #(.WIDTH(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .len     (len),
    .expired (expired)
  );

  // Length of the state currently being timed.
  always_comb begin
    len = CW'(PHASE_CYCLES);
    case (state)
      ST_ADDR: len = CW'(PHASE_CYCLES);
      ST_GAP:  len = CW'(GAP_CYCLES);
      ST_DATA: len = CW'(PHASE_CYCLES);
      default: len = CW'(PHASE_CYCLES);
    endcase
  end

  // Next-state logic; every state change reloads the phase timer.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_ADDR;
          load       = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (expired) begin
          next_state = ST_GAP;
          load       = 1'b1;
        end else begin
          next_state = ST_ADDR;
        end
      end
      ST_GAP: begin
        if (expired) begin
          next_state = ST_DATA;
          load       = 1'b1;
        end else begin
          next_state = ST_GAP;
        end
      end
      ST_DATA: begin
        if (expired) begin
          next_state = ST_FINISH;
          load       = 1'b1;
        end else begin
          next_state = ST_DATA;
        end
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
        load       = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
        load       = 1'b1;
      end
    endcase
  end

  // Request fields as they will be held next cycle. The outputs are
  // registered from the next state, so the accept edge must already see the
  // newly captured request rather than the stale one.
  always_comb begin
    if (accept) begin
      rw_n    = rw;
      addr_n  = addr;
      wdata_n = wdata;
    end else begin
      rw_n    = rw_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
    end
  end

  // Byte to present on the AD bus in the coming cycle.
  always_comb begin
    bus_next = 8'h00;
    case (next_state)
      ST_ADDR: bus_next = addr_n;
      ST_DATA: bus_next = (rw_n == RW_READ) ? 8'h00 : wdata_n;
      default: bus_next = 8'h00;
    endcase
  end

  // State register and registered generator/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_signals <= 1'b0;
      read       <= 1'b0;
      dato       <= 1'b0;
      bus_out    <= 8'h00;
    end else begin
      state      <= next_state;
      busy       <= (next_state != ST_IDLE);
      done       <= (next_state == ST_FINISH);
      en_signals <= (next_state == ST_ADDR) || (next_state == ST_DATA);
      read       <= (next_state == ST_DATA) && (rw_n == RW_READ);
      dato       <= (next_state == ST_DATA);
      bus_out    <= bus_next;
    end
  end

  // Request capture; only an accepted start changes the held fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= RW_WRITE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      rw_q    <= rw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
    end
  end

  // Read data path: every latch strobe in a read data phase overwrites the
  // shadow (last sample wins); the shadow is published in FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_shadow <= 8'h00;
      rdata        <= 8'h00;
    end else begin
      if ((state == ST_DATA) && (rw_q == RW_READ) && ll) begin
        rdata_shadow <= bus_in;
      end else begin
        rdata_shadow <= rdata_shadow;
      end
      if ((state == ST_FINISH) && (rw_q == RW_READ)) begin
        rdata <= rdata_shadow;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_rtc_transaction_ctrl.sv
// tb_rtc_transaction_ctrl: self-checking bench for rtc_transaction_ctrl.
// A transaction-level model (cycle offset since the accepting edge) predicts
// every output; a negedge process compares the DUT against it each cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_rtc_transaction_ctrl;

  localparam int P     = 32;
  localparam int G     = 2;
  localparam int TOTAL = 2 * P + G + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       en_signals;
  logic       read;
  logic       dato;
  logic [7:0] bus_out;
  logic [7:0] bus_in;
  logic       ll;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  rtc_transaction_ctrl #(.PHASE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rw         (rw),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .en_signals (en_signals),
    .read       (read),
    .dato       (dato),
    .bus_out    (bus_out),
    .bus_in     (bus_in),
    .ll         (ll)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic       m_active;
  int         m_t;
  logic       m_rw;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_shadow;
  logic [7:0] m_rdata;

  function automatic logic in_addr(input int t);
    return t < P;
  endfunction

  function automatic logic in_data(input int t);
    return (t >= P + G) && (t < 2 * P + G);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_rw     <= 1'b0;
      m_addr   <= 8'h00;
      m_wdata  <= 8'h00;
      m_shadow <= 8'h00;
      m_rdata  <= 8'h00;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_rw     <= rw;
        m_addr   <= addr;
        m_wdata  <= wdata;
      end
    end else begin
      if (m_rw && ll && in_data(m_t)) m_shadow <= bus_in;
      if (m_t == TOTAL - 1) begin
        m_active <= 1'b0;
        if (m_rw) m_rdata <= m_shadow;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      logic       e_en, e_dato, e_read, e_done;
      logic [7:0] e_bus;
      e_en   = m_active && (in_addr(m_t) || in_data(m_t));
      e_dato = m_active && in_data(m_t);
      e_read = e_dato && m_rw;
      e_done = m_active && (m_t == TOTAL - 1);
      if (!m_active)          e_bus = 8'h00;
      else if (in_addr(m_t))  e_bus = m_addr;
      else if (in_data(m_t))  e_bus = m_rw ? 8'h00 : m_wdata;
      else                    e_bus = 8'h00;
      check("busy",       int'(busy),       int'(m_active));
      check("done",       int'(done),       int'(e_done));
      check("en_signals", int'(en_signals), int'(e_en));
      check("read",       int'(read),       int'(e_read));
      check("dato",       int'(dato),       int'(e_dato));
      check("bus_out",    int'(bus_out),    int'(e_bus));
      check("rdata",      int'(rdata),      int'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] w);
    start = 1'b1;
    rw    = r;
    addr  = a;
    wdata = w;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int busy_cnt, en_cnt, done_cnt, low, k;
    reset  = 1'b1;
    start  = 1'b0;
    rw     = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
    bus_in = 8'h00;
    ll     = 1'b0;
    #2;
    check("reset_busy",  int'(busy),       0);
    check("reset_en",    int'(en_signals), 0);
    check("reset_bus",   int'(bus_out),    0);
    check("reset_rdata", int'(rdata),      0);
    tick();
    tick();
    reset  = 1'b0;
    chk_on = 1'b1;
    tick();

    // Write: busy 67 cycles, enable 64 cycles, rdata untouched.
    issue(1'b0, 8'h21, 8'h45);
    busy_cnt = 0;
    en_cnt   = 0;
    for (int t = 0; t < 70; t++) begin
      if (busy) busy_cnt++;
      if (en_signals) en_cnt++;
      tick();
    end
    check("write_busy_cycles", busy_cnt, 67);
    check("write_en_cycles",   en_cnt,   64);
    check("write_rdata",       int'(rdata), 8'h00);

    // Read: strobes outside the data phase must be ignored.
    issue(1'b1, 8'h22, 8'h99);
    for (int t = 0; t < 70; t++) begin
      ll     = (t == 10) || (t >= 40 && t <= 44) || (t == 66);
      bus_in = (t >= 40 && t <= 44) ? 8'h5A : 8'hFF;
      tick();
    end
    ll = 1'b0;
    check("read_rdata", int'(rdata), 8'h5A);

    // Several samples in one window: the last wins.
    issue(1'b1, 8'h23, 8'h00);
    for (int t = 0; t < 70; t++) begin
      ll     = (t >= 40 && t <= 43);
      bus_in = (t <= 41) ? 8'h11 : 8'h33;
      tick();
    end
    ll = 1'b0;
    check("multi_ll_rdata", int'(rdata), 8'h33);

    // Starts while busy (incl. the done cycle) ignored; next idle cycle accepted.
    issue(1'b0, 8'h30, 8'h31);
    done_cnt = 0;
    for (int t = 0; t < 68; t++) begin
      start = (t == 10) || (t == 40) || (t == 66) || (t == 67);
      addr  = 8'(t);
      if (done) done_cnt++;
      tick();
    end
    start = 1'b0;
    check("ignored_done_count", done_cnt, 1);
    check("restart_busy",       int'(busy), 1);
    for (int t = 0; t < 70; t++) tick();

    // Reset inside the data phase drops the transaction immediately.
    issue(1'b0, 8'h40, 8'h41);
    for (int t = 0; t < 50; t++) tick();
    #2 reset = 1'b1;
    #1;
    check("midreset_en",   int'(en_signals), 0);
    check("midreset_busy", int'(busy),       0);
    check("midreset_bus",  int'(bus_out),    0);
    check("midreset_done", int'(done),       0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    issue(1'b0, 8'h42, 8'h43);
    done_cnt = 0;
    for (int t = 0; t < 70; t++) begin
      if (done) done_cnt++;
      tick();
    end
    check("post_reset_done", done_cnt, 1);

    // Back-to-back read then write.
    issue(1'b1, 8'h50, 8'h00);
    for (int t = 0; t < 66; t++) begin
      ll     = (t == 45);
      bus_in = 8'hA7;
      tick();
    end
    ll  = 1'b0;
    low = 0;
    k   = 0;
    while (busy && k < 100) begin
      if (!en_signals) low++;
      tick();
      k++;
    end
    check("b2b_wait_timeout", int'(k < 100), 1);
    if (!en_signals) low++;
    tick();
    if (!en_signals) low++;
    issue(1'b0, 8'h51, 8'h52);
    if (!en_signals) low++;
    check("b2b_gap_ok", int'(low >= G + 1), 1);
    for (int t = 0; t < 70; t++) tick();
    check("b2b_rdata_kept", int'(rdata), 8'hA7);

    // Randomised traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 reset = 1'b1;
      end else if (i == 1502) begin
        reset = 1'b0;
      end
      start  = ($urandom_range(0, 15) == 0);
      rw     = 1'($urandom_range(0, 1));
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
      ll     = ($urandom_range(0, 3) == 0);
      bus_in = 8'($urandom);
      tick();
    end
    start = 1'b0;
    ll    = 1'b0;
    for (int t = 0; t < 80; t++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
